// File: rtl/adc_conv_sched.sv
// Round-robin conversion scheduler for the shared ADC mux and fixed-point converter.
// Define ADC_SCHED_TIMEOUT_EN to build the CONVERT-state timeout counter and error flags.
module adc_conv_sched #(
  parameter int FP_WIDTH       = 32,
  parameter int SETTLE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ADC_CLK,
  input  logic                    REG_RST_N,
  input  logic                    SYS_EN,
  input  logic [SETTLE_WIDTH-1:0] SETTLE_CYC,
  input  logic [1:0]              REQ,
  input  logic [1:0]              REQ_CH,
  input  logic                    ADC_DONE,
  input  logic [FP_WIDTH-1:0]     ADC_CAL_OUT,
  output logic                    ADC_SEL,
  output logic                    ADC_EN,
  output logic [FP_WIDTH-1:0]     ADC_RESULT,
  output logic [1:0]              RES_VALID,
  output logic                    RES_ERR,
  output logic                    BUSY,
  output logic                    ERR_TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    chan_valid_q, chan_valid_d;
  logic                    prio_q, prio_d;
  logic                    grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
  logic [FP_WIDTH-1:0]     result_q, result_d;
  logic [1:0]              valid_q, valid_d;

  logic grant_idx;
  logic grant_ch;
  logic need_settle;

  // prio_q names the requester that wins if both are asking.
  assign grant_idx   = REQ[prio_q] ? prio_q : ~prio_q;
  assign grant_ch    = REQ_CH[grant_idx];
  assign need_settle = (grant_ch != sel_q) || !chan_valid_q;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    en_d         = 1'b0;
    chan_valid_d = chan_valid_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    settle_d     = settle_q;
    result_d     = result_q;
    valid_d      = 2'b00;
    busy_d       = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
    tmo_d        = '0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
`endif
    if (!SYS_EN) begin
      // Abort: mux state is kept so the next grant can skip the settle.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|REQ) begin
            grant_d = grant_idx;
            sel_d   = grant_ch;
            if (need_settle && (SETTLE_CYC != '0)) begin
              state_d  = SETTLE;
              settle_d = SETTLE_CYC;
            end else begin
              state_d      = CONVERT;
              en_d         = 1'b1;
              chan_valid_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_WIDTH'(1)) begin
            state_d      = CONVERT;
            en_d         = 1'b1;
            chan_valid_d = 1'b1;
          end else begin
            settle_d = settle_q - SETTLE_WIDTH'(1);
          end
        end
        CONVERT: begin
          if (ADC_DONE) begin
            state_d  = DELIVER;
            result_d = ADC_CAL_OUT;
            valid_d  = grant_q ? 2'b10 : 2'b01;
            prio_d   = ~grant_q;
          end
`ifdef ADC_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_d      = DELIVER;
            result_d     = '0;
            valid_d      = grant_q ? 2'b10 : 2'b01;
            prio_d       = ~grant_q;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end
`endif
          else begin
            en_d = 1'b1;
`ifdef ADC_SCHED_TIMEOUT_EN
            tmo_d = tmo_q + TMO_W'(1);
`endif
          end
        end
        DELIVER: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ADC_CLK or negedge REG_RST_N) begin
    if (!REG_RST_N) begin
      state_q      <= IDLE;
      sel_q        <= 1'b1;
      en_q         <= 1'b0;
      chan_valid_q <= 1'b0;
      prio_q       <= 1'b0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      settle_q     <= '0;
      result_q     <= '0;
      valid_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      chan_valid_q <= chan_valid_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      settle_q     <= settle_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  always_ff @(posedge ADC_CLK or negedge REG_RST_N) begin
    if (!REG_RST_N) begin
      tmo_q        <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign RES_ERR     = err_q;
  assign ERR_TIMEOUT = err_sticky_q;
`else
  assign RES_ERR     = 1'b0;
  assign ERR_TIMEOUT = 1'b0;
`endif

  assign ADC_SEL    = sel_q;
  assign ADC_EN     = en_q;
  assign ADC_RESULT = result_q;
  assign RES_VALID  = valid_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_adc_conv_sched.sv
// Bench for adc_conv_sched: directed scenarios plus randomized traffic against a timestamp model.
// Builds with or without ADC_SCHED_TIMEOUT_EN.
module tb_adc_conv_sched;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sys_en = 1'b1;
  logic [7:0]  settle = 8'd0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_ch = 2'b00;
  logic        done = 1'b0;
  logic [31:0] cal = 32'd0;

  logic        adc_sel, adc_en, res_err, busy, err_timeout;
  logic [31:0] adc_result;
  logic [1:0]  res_valid;

  int n_chk = 0;
  int n_err = 0;

  adc_conv_sched #(
    .FP_WIDTH(32),
    .SETTLE_WIDTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ADC_CLK(clk),
    .REG_RST_N(rst_n),
    .SYS_EN(sys_en),
    .SETTLE_CYC(settle),
    .REQ(req),
    .REQ_CH(req_ch),
    .ADC_DONE(done),
    .ADC_CAL_OUT(cal),
    .ADC_SEL(adc_sel),
    .ADC_EN(adc_en),
    .ADC_RESULT(adc_result),
    .RES_VALID(res_valid),
    .RES_ERR(res_err),
    .BUSY(busy),
    .ERR_TIMEOUT(err_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: a transaction is a grant edge plus the edge it enters conversion
  // (grant + settle); everything else follows from edge arithmetic.
  int          cyc = 0;
  bit          m_act = 0, m_dlv = 0, m_g = 0, m_sel = 1, m_cv = 0, m_prio = 0;
  bit          m_err = 0, m_errs = 0;
  int          m_conv = 0;
  logic [31:0] m_res = 32'd0;
  logic [1:0]  m_rv = 2'b00;

  task automatic m_finish(input logic [31:0] v, input bit e);
    m_res  = v;
    m_rv   = m_g ? 2'b10 : 2'b01;
    m_err  = e;
    if (e) m_errs = 1;
    m_act  = 0;
    m_dlv  = 1;
    m_prio = !m_g;
  endtask

  initial begin
    bit sw;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 0; m_dlv = 0; m_g = 0; m_sel = 1; m_cv = 0; m_prio = 0;
        m_err = 0; m_errs = 0; m_res = 32'd0; m_rv = 2'b00; m_conv = 0;
      end else begin
        cyc++;
        m_rv  = 2'b00;
        m_err = 0;
        if (m_dlv) begin
          m_dlv = 0;
        end else if (!sys_en) begin
          m_act = 0;
        end else if (!m_act) begin
          if (req != 2'b00) begin
            m_g    = req[m_prio] ? m_prio : !m_prio;
            sw     = !m_cv || (req_ch[m_g] != m_sel);
            m_conv = cyc + (sw ? int'(settle) : 0);
            m_sel  = req_ch[m_g];
            m_act  = 1;
            if (m_conv == cyc) m_cv = 1;
          end
        end else if (cyc == m_conv) begin
          m_cv = 1;
        end else if (cyc > m_conv) begin
          if (done) m_finish(cal, 0);
`ifdef ADC_SCHED_TIMEOUT_EN
          else if (cyc - m_conv == TMO) m_finish(32'd0, 1);
`endif
        end
      end
    end
  end

  // One compare process against the model, every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("cmp_adc_en",      32'(adc_en),      32'(m_act && (cyc >= m_conv)));
      chk("cmp_busy",        32'(busy),        32'(m_act || m_dlv));
      chk("cmp_adc_sel",     32'(adc_sel),     32'(m_sel));
      chk("cmp_res_valid",   32'(res_valid),   32'(m_rv));
      chk("cmp_adc_result",  adc_result,       m_res);
      chk("cmp_res_err",     32'(res_err),     32'(m_err));
      chk("cmp_err_timeout", 32'(err_timeout), 32'(m_errs));
    end
  end

  task automatic wait_en(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (adc_en === 1'b1) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL wait_adc_en actual=no ADC_EN required=ADC_EN within 40 cycles");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},    32'(adc_sel),     32'd1);
    chk({tag, "_en"},     32'(adc_en),      32'd0);
    chk({tag, "_result"}, adc_result,       32'd0);
    chk({tag, "_valid"},  32'(res_valid),   32'd0);
    chk({tag, "_err"},    32'(res_err),     32'd0);
    chk({tag, "_busy"},   32'(busy),        32'd0);
    chk({tag, "_errto"},  32'(err_timeout), 32'd0);
  endtask

  initial begin
    int cnt;
    int lat;
    bit got;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Cold channel: settle of 4, done three cycles after ADC_EN rises.
    req = 2'b01; req_ch = 2'b01; settle = 8'd4;
    wait_en(cnt);
    chk("t1_en_delay", 32'(cnt), 32'd5);
    repeat (2) @(negedge clk);
    done = 1'b1; cal = 32'h3F80_0000;
    @(negedge clk);
    done = 1'b0;
    chk("t1_valid",  32'(res_valid), 32'h1);
    chk("t1_result", adc_result,     32'h3F80_0000);
    chk("t1_en_off", 32'(adc_en),    32'd0);
    req = 2'b00;
    @(negedge clk);
    chk("t1_valid_pulse", 32'(res_valid), 32'd0);
    chk("t1_idle",        32'(busy),      32'd0);

    // Same channel again: no settle.
    req = 2'b01;
    wait_en(cnt);
    chk("t2_en_delay", 32'(cnt), 32'd1);
    done = 1'b1; cal = 32'h4000_0000;
    @(negedge clk);
    done = 1'b0;
    chk("t2_valid",  32'(res_valid), 32'h1);
    chk("t2_result", adc_result,     32'h4000_0000);
    req = 2'b00;
    @(negedge clk);

    // SYS_EN drop in CONVERT, then a stray ADC_DONE.
    req = 2'b01;
    wait_en(cnt);
    sys_en = 1'b0;
    @(negedge clk);
    chk("t4_en_off", 32'(adc_en),    32'd0);
    chk("t4_busy",   32'(busy),      32'd0);
    chk("t4_valid",  32'(res_valid), 32'd0);
    done = 1'b1; cal = 32'hDEAD_BEEF;
    @(negedge clk);
    done = 1'b0;
    chk("t4_stray_valid",  32'(res_valid), 32'd0);
    chk("t4_stray_result", adc_result,     32'h4000_0000);
    req = 2'b00; sys_en = 1'b1;
    @(negedge clk);

`ifdef ADC_SCHED_TIMEOUT_EN
    // Converter never answers.
    req = 2'b01;
    wait_en(cnt);
    cnt = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cnt++;
      if (res_valid !== 2'b00) got = 1;
    end
    chk("t5_tmo_cycles", 32'(cnt),         32'd16);
    chk("t5_valid",      32'(res_valid),   32'h1);
    chk("t5_res_err",    32'(res_err),     32'd1);
    chk("t5_result",     adc_result,       32'd0);
    chk("t5_errto",      32'(err_timeout), 32'd1);
    req = 2'b00;
    repeat (5) @(negedge clk);
    chk("t5_errto_sticky", 32'(err_timeout), 32'd1);
`endif

    // Both requesting on different channels: grants and mux alternate.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11; req_ch = 2'b01; settle = 8'd2;
    for (int i = 0; i < 4; i++) begin
      wait_en(cnt);
      chk("t3_settle_delay", 32'(cnt), (i == 0) ? 32'd3 : 32'd4);
      done = 1'b1; cal = $urandom;
      @(negedge clk);
      done = 1'b0;
      chk("t3_grant", 32'(res_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_sel",   32'(adc_sel),   (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a settle.
    req = 2'b01; req_ch = 2'b01; settle = 8'd10;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async_rst");
    @(negedge clk);
    rst_n = 1'b1; settle = 8'd2;
    wait_en(cnt);
    chk("t6_settle_after_rst", 32'(cnt), 32'd3);
    done = 1'b1; cal = 32'h1234_5678;
    @(negedge clk);
    done = 1'b0;
    chk("t6_valid", 32'(res_valid), 32'h1);
    req = 2'b00;
    @(negedge clk);

    // Randomized traffic: requesters hold until served, stray ADC_DONE outside conversions.
    lat = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (req[r] && m_rv[r]) begin
          req[r] = 1'b0;
        end else if (!req[r] && ($urandom_range(3) == 0)) begin
          req[r]    = 1'b1;
          req_ch[r] = 1'($urandom_range(1));
        end
      end
      sys_en = ($urandom_range(59) != 0);
      settle = 8'($urandom_range(5));
      cal    = $urandom;
      if (m_act && (cyc >= m_conv)) begin
        if (cyc == m_conv) begin
`ifdef ADC_SCHED_TIMEOUT_EN
          lat = ($urandom_range(4) == 0) ? 100 : int'($urandom_range(6));
`else
          lat = int'($urandom_range(6));
`endif
        end
        done = (cyc - m_conv == lat);
      end else begin
        done = ($urandom_range(5) == 0);
      end
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_sched.md
# adc_conv_sched

Conversion scheduler for the shared ADC front end (ADC mux plus fixed-point ADC converter). It sits between two requesters and the single converter: requester 0 is the SPGD state machine, requester 1 is the housekeeping/monitor path. It arbitrates round-robin, drives the mux select, and inserts a programmable settle delay after a channel switch. It runs the converter's ADC_EN/ADC_DONE handshake and returns the calibrated result to the granted requester.

## Interface
- FP_WIDTH, 32, width of calibrated converter result
- SETTLE_WIDTH, 8, width of settle-delay count
- TIMEOUT_CYCLES, 1024, conversion timeout in cycles (used only with ADC_SCHED_TIMEOUT_EN)

Ports:
- ADC_CLK  in  1  system clock, all logic rising-edge
- REG_RST_N  in  1  asynchronous active-low reset
- SYS_EN  in  1  scheduler enable; low aborts and idles
- SETTLE_CYC  in  SETTLE_WIDTH  cycles to wait after mux channel change
- REQ  in  2  per-requester conversion request, level, held until own RES_VALID
- REQ_CH  in  2  per-requester channel: 1 = IN1/ADC_A, 0 = IN2/ADC_B
- ADC_DONE  in  1  converter completion strobe
- ADC_CAL_OUT  in  FP_WIDTH  converter calibrated result
- ADC_SEL  out  1  mux select / calibration select (1 = IN1)
- ADC_EN  out  1  converter enable
- ADC_RESULT  out  FP_WIDTH  registered result, valid with RES_VALID
- RES_VALID  out  2  one-cycle per-requester completion pulse
- RES_ERR  out  1  qualifies RES_VALID: conversion timed out
- BUSY  out  1  high in any state except IDLE
- ERR_TIMEOUT  out  1  sticky timeout flag, cleared only by reset

## Operation
- States: IDLE, SETTLE, CONVERT, DELIVER.
- IDLE, SYS_EN=1, any REQ set: grant round-robin. Priority goes to the requester not granted last. After reset, requester 0 has priority. The granted index and its REQ_CH are captured; ADC_SEL is updated to the captured channel.
- If the captured channel differs from the current ADC_SEL, or no conversion has happened since reset (chan_valid=0), go to SETTLE with counter = SETTLE_CYC. Otherwise go to CONVERT.
- If SETTLE_CYC = 0, go directly to CONVERT.
- SETTLE: decrement counter each cycle; at 1, go to CONVERT. chan_valid is set on entry to CONVERT.
- CONVERT: ADC_EN=1. ADC_DONE sampled high in any CONVERT cycle, including the first, captures ADC_CAL_OUT into ADC_RESULT. Then go to DELIVER.
- DELIVER: RES_VALID[grant]=1 for exactly one cycle, ADC_EN=0, then go to IDLE.
- ADC_DONE outside CONVERT is ignored.
- SYS_EN low in any state: next cycle IDLE, ADC_EN=0. No RES_VALID is issued. ADC_SEL and chan_valid are kept. The round-robin pointer does not advance.
- SETTLE_CYC is sampled only at grant; changes mid-settle have no effect.
- Reset values: ADC_SEL=1, ADC_EN=0, ADC_RESULT=0, RES_VALID=0, RES_ERR=0, BUSY=0, ERR_TIMEOUT=0, chan_valid=0, pointer favours requester 0, state IDLE.

## Timing
- REQ seen in IDLE at edge t:
  - same channel, chan_valid=1: ADC_EN high from t+1.
  - channel switch: ADC_EN high from t+1+SETTLE_CYC.
- ADC_DONE high at edge d: ADC_RESULT and RES_VALID valid during cycle d+1; ADC_EN low from d+1; IDLE at d+2.
- A requester drops REQ in the cycle after RES_VALID. IDLE at d+2 then re-arbitrates, so the earliest next ADC_EN is d+3.
- Both REQ rising in the same cycle: one grant only; the other is served next.
- RES_VALID is never asserted on both bits at once.

## Configuration
- ADC_SCHED_TIMEOUT_EN defined:
  - CONVERT runs a cycle counter. If it reaches TIMEOUT_CYCLES without ADC_DONE, go to DELIVER with ADC_RESULT=0 and RES_ERR=1 alongside RES_VALID, and set ERR_TIMEOUT.
  - ADC_DONE on the same edge the counter expires wins as a normal completion.
- Undefined: CONVERT waits indefinitely; RES_ERR and ERR_TIMEOUT are tied 0; no counter is built.

## Test plan
- Reset, then REQ=2'b01, REQ_CH[0]=1, SETTLE_CYC=4, ADC_DONE 3 cycles after ADC_EN rises with ADC_CAL_OUT=32'h3F80_0000 -> ADC_EN rises 5 cycles after request; RES_VALID=2'b01 for one cycle; ADC_RESULT=32'h3F80_0000.
- Second request from requester 0 on the same channel -> no settle; ADC_EN high the cycle after IDLE samples REQ.
- REQ=2'b11 held, channels 1 and 0 -> grants alternate 0,1,0,1; ADC_SEL toggles 1,0,1,0; each grant incurs a settle.
- SYS_EN dropped during CONVERT -> ADC_EN low next cycle, no RES_VALID, BUSY=0. A later ADC_DONE is ignored.
- With ADC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ADC_DONE -> after 16 CONVERT cycles RES_VALID with RES_ERR=1, ADC_RESULT=0, ERR_TIMEOUT=1, which stays 1 until REG_RST_N is asserted.
- REG_RST_N asserted mid-SETTLE -> all outputs at reset values immediately (asynchronously); the next request incurs a settle.
